io_bridge: RTL

- Parametrised successor to the single-cycle memory/IO data mux in the CPU datapath.
- Sits between the ALU address/register-file write data and data memory, and the board peripherals.
- Routes loads and stores to memory or to N_IN input and N_OUT output IO channels.
- Adds input synchronisation, per-channel change-event flags, registered output latches, and a multi-cycle IO read with a stall handshake to the pipeline.

---
 rtl/io_bridge_if.sv | 31 +++
 rtl/io_bridge.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/io_bridge_if.sv
// Pipeline-side bundle for io_bridge: memory/IO strobes and data in, routed data and stall out.
// The master drives loads/stores and the raw peripheral inputs; the slave is the bridge.
interface io_bridge_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 4
);
   logic                   m_read;
   logic                   m_write;
   logic                   io_read;
   logic                   io_write;
   logic [31:0]            addr_in;
   logic [31:0]            m_rdata;
   logic [31:0]            reg_wdata;
   logic [16*N_IN-1:0]     in_data;
   logic [31:0]            addr;
   logic [31:0]            r_data;
   logic [31:0]            w_data;
   logic                   io_stall;
   logic [16*N_OUT-1:0]    out_data;
   logic                   event_any;

   modport master (
      output m_read, m_write, io_read, io_write, addr_in, m_rdata, reg_wdata, in_data,
      input  addr, r_data, w_data, io_stall, out_data, event_any
   );

   modport slave (
      input  m_read, m_write, io_read, io_write, addr_in, m_rdata, reg_wdata, in_data,
      output addr, r_data, w_data, io_stall, out_data, event_any
   );
endinterface

// File: rtl/io_bridge.sv
// Memory/IO bridge: routes loads and stores to data memory or to synchronised input channels,
// event flags and output latches, stalling the pipeline for the duration of an IO read.
module io_bridge #(
   parameter int          N_IN       = 4,
   parameter int          N_OUT      = 4,
   parameter int          RD_LAT     = 2,
   parameter logic [31:0] IDLE_WDATA = 32'hFFFF_FFFF
) (
   input logic        clk,
   input logic        rst,
   io_bridge_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [31:0]        rd_buf_q, rd_buf_d;
   logic               rd_load;
   logic [2:0]         ch;
   logic               ev_region;
   logic [16*N_IN-1:0] s_flat;
   logic [N_IN-1:0]    ev_vec;
   logic [15:0]        s_sel;
   logic               ev_sel;

   assign ch        = bus.addr_in[4:2];
   assign ev_region = bus.addr_in[5];

   genvar gi;

   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_in
         logic [15:0] sync1_q, sync1_d;
         logic [15:0] sync2_q, sync2_d;
         logic [15:0] s_q, s_d;
         logic        ev_q, ev_d;

         // A change seen between sample and sync2 outranks a read-clear on the same edge.
         always_comb begin
            sync1_d = bus.in_data[16*gi +: 16];
            sync2_d = sync1_q;
            s_d     = sync2_q;
            ev_d    = ev_q;
            if (rd_load && ev_region && (ch == 3'(gi)))
               ev_d = 1'b0;
            if (s_q != sync2_q)
               ev_d = 1'b1;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q <= '0;
               sync2_q <= '0;
               s_q     <= '0;
               ev_q    <= 1'b0;
            end else begin
               sync1_q <= sync1_d;
               sync2_q <= sync2_d;
               s_q     <= s_d;
               ev_q    <= ev_d;
            end
         end

         assign s_flat[16*gi +: 16] = s_q;
         assign ev_vec[gi]          = ev_q;
      end

      for (gi = 0; gi < N_OUT; gi++) begin : g_out
         logic [15:0] out_q, out_d;

         always_comb begin
            out_d = out_q;
            if (bus.io_write && !ev_region && (ch == 3'(gi)))
               out_d = bus.reg_wdata[15:0];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               out_q <= '0;
            else
               out_q <= out_d;
         end

         assign bus.out_data[16*gi +: 16] = out_q;
      end
   endgenerate

   // Channels with no matching index fall through to zero, which covers out-of-range reads.
   always_comb begin
      s_sel  = '0;
      ev_sel = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         if (ch == 3'(k)) begin
            s_sel  = s_flat[16*k +: 16];
            ev_sel = ev_vec[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rd_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_buf_q <= rd_buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.io_read) begin
               if (LAT == 3'd0) begin
                  state_d = ST_DONE;
                  rd_load = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q != 3'd0)
               cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = ST_DONE;
               rd_load = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      rd_buf_d = rd_buf_q;
      if (rd_load)
         rd_buf_d = ev_region ? {31'h0, ev_sel} : {16'h0, s_sel};
   end

   // Stall is gated by rst so the pipeline is released the moment reset asserts.
   always_comb begin
      bus.io_stall = 1'b0;
      if (!rst)
         bus.io_stall = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && bus.io_read);

      if (state_q == ST_DONE)
         bus.r_data = rd_buf_q;
      else if (bus.io_read)
         bus.r_data = '0;
      else
         bus.r_data = bus.m_rdata;

      bus.w_data    = (bus.m_write || bus.io_write) ? bus.reg_wdata : IDLE_WDATA;
      bus.addr      = bus.addr_in;
      bus.event_any = |ev_vec;
   end
endmodule
